// File: rtl/bus_xfer_pkg.sv
// Shared types for the bus transfer sequencer: FSM states and register-select decode.
// Latency: none (types and a pure function).
// Backpressure: not applicable.
package bus_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } state_t;

  // One bit of a register-select one-hot; an index past the bus width selects nothing.
  function automatic logic onehot_bit(input int idx, input int pos, input int nreg);
    return (idx < nreg) && (idx == pos);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping upward.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!gnt_vld && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_sched.sv
// Sequences src->dst copies over the shared tri-state bus, round-robin across requesters.
// Latency: accept T, drive T+1, write T+2, done pulse T+3; next accept at T+3+TURNAROUND.
// Backpressure: req_ready only in IDLE and only to the granted requester; others hold.
module bus_xfer_sched
  import bus_xfer_pkg::*;
#(
  parameter int NREG       = 8,
  parameter int NREQ       = 2,
  parameter int TURNAROUND = 1,
  localparam int IDXW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IDXW-1:0] req_src,
  input  logic [NREQ*IDXW-1:0] req_dst,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      done,
  output logic [NREG-1:0]      reg_oenable,
  output logic [NREG-1:0]      reg_wenable,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gid_q;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_vld;
  logic [IDXW-1:0] sel_src;
  logic [IDXW-1:0] sel_dst;
  logic [IDXW-1:0] dst_q;
  logic [NREG-1:0] sel_src_oh;
  logic [NREG-1:0] dst_q_oh;
  logic [TW-1:0]   turn_cnt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign sel_src   = req_src[gnt_idx*IDXW +: IDXW];
  assign sel_dst   = req_dst[gnt_idx*IDXW +: IDXW];

  always_comb begin
    sel_src_oh = '0;
    dst_q_oh   = '0;
    for (int i = 0; i < NREG; i++) begin
      sel_src_oh[i] = onehot_bit(int'(sel_src), i, NREG);
      dst_q_oh[i]   = onehot_bit(int'(dst_q), i, NREG);
    end
  end

  // Enables are decoded from the state being entered so they come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      gid_q       <= '0;
      dst_q       <= '0;
      turn_cnt    <= '0;
      reg_oenable <= '0;
      reg_wenable <= '0;
      done        <= '0;
      busy        <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            dst_q       <= sel_dst;
            gid_q       <= gnt_idx;
            ptr         <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            reg_oenable <= sel_src_oh;
            reg_wenable <= '0;
            busy        <= 1'b1;
            state       <= DRIVE;
          end
        end
        DRIVE: begin
          reg_wenable <= dst_q_oh;
          state       <= WRITE;
        end
        WRITE: begin
          done[gid_q] <= 1'b1;
          reg_oenable <= '0;
          reg_wenable <= '0;
          if (TURNAROUND == 0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            turn_cnt <= TW'(TURNAROUND - 1);
            state    <= TURN;
          end
        end
        TURN: begin
          if (turn_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Bench for bus_xfer_sched: dut_a (NREG=8, TURNAROUND=1) and dut_b (NREG=6, TURNAROUND=0)
// checked every cycle against a queue of expected transfers built from the driven requests.
module tb_bus_xfer_sched;

  typedef struct {
    int         dut;
    int         t0;
    int         gid;
    logic [7:0] soh;
    logic [7:0] doh;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [1:0] vld_a, vld_b, rdy_a, rdy_b, done_a, done_b;
  logic [5:0] src_a, dst_a, src_b, dst_b;
  logic [7:0] oen_a, wen_a;
  logic [5:0] oen_b, wen_b;
  logic       busy_a, busy_b;

  bus_xfer_sched #(.NREG(8), .NREQ(2), .TURNAROUND(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req_valid(vld_a), .req_src(src_a), .req_dst(dst_a),
    .req_ready(rdy_a), .done(done_a), .reg_oenable(oen_a), .reg_wenable(wen_a), .busy(busy_a)
  );

  bus_xfer_sched #(.NREG(6), .NREQ(2), .TURNAROUND(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_valid(vld_b), .req_src(src_b), .req_dst(dst_b),
    .req_ready(rdy_b), .done(done_b), .reg_oenable(oen_b), .reg_wenable(wen_b), .busy(busy_b)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  xfer_t      sbq[$];
  int         ptr_m[2];
  int         n_acc[2];
  int         n_done[2];
  int         last_t[2];
  int         last_g[2];
  logic [7:0] prev_oen[2];

  function automatic logic [7:0] oh(input int idx, input int nreg);
    return (idx < nreg) ? (8'h01 << idx) : 8'h00;
  endfunction

  // Per-cycle scoreboard check of one DUT; also records acceptances predicted by the model.
  task automatic mon_check(input int d);
    logic       rst, bsy, e_busy;
    logic [1:0] vld, rdy, dn, e_done, e_rdy;
    logic [5:0] src, dst;
    logic [7:0] oen, wen, e_oen, e_wen;
    int nreg, ta, idx, k, g, j;
    if (d == 0) begin
      rst = rst_n_a; vld = vld_a; src = src_a; dst = dst_a; rdy = rdy_a; dn = done_a;
      oen = oen_a; wen = wen_a; bsy = busy_a; nreg = 8; ta = 1;
    end else begin
      rst = rst_n_b; vld = vld_b; src = src_b; dst = dst_b; rdy = rdy_b; dn = done_b;
      oen = {2'b00, oen_b}; wen = {2'b00, wen_b}; bsy = busy_b; nreg = 6; ta = 0;
    end
    e_oen = '0; e_wen = '0; e_done = '0; e_rdy = '0; e_busy = 1'b0; idx = -1;
    foreach (sbq[i]) if (sbq[i].dut == d) idx = i;
    if (idx >= 0) begin
      k = cyc - sbq[idx].t0;
      if (k == 1) e_oen = sbq[idx].soh;
      if (k == 2) begin e_oen = sbq[idx].soh; e_wen = sbq[idx].doh; end
      if (k == 3) e_done = 2'b01 << sbq[idx].gid;
      e_busy = (k >= 1) && (k <= 2 + ta);
      if (k >= 3 && k >= 2 + ta) sbq.delete(idx);
    end
    if (!rst) begin
      n_cmp++;
      if ({oen, wen, dn, bsy} !== 19'd0) begin
        n_bad++;
        $display("FAIL in_reset dut%0d cyc%0d: oen=%h wen=%h done=%b busy=%b, want all zero",
                 d, cyc, oen, wen, dn, bsy);
      end
      prev_oen[d] = '0;
      return;
    end
    if (!e_busy)
      for (int m = 0; m < 2; m++) begin
        j = (ptr_m[d] + m) % 2;
        if (e_rdy == 2'b00 && vld[j]) e_rdy[j] = 1'b1;
      end
    n_cmp++;
    if (oen !== e_oen) begin n_bad++; $display("FAIL oenable dut%0d cyc%0d: got %h want %h", d, cyc, oen, e_oen); end
    n_cmp++;
    if (wen !== e_wen) begin n_bad++; $display("FAIL wenable dut%0d cyc%0d: got %h want %h", d, cyc, wen, e_wen); end
    n_cmp++;
    if (dn !== e_done) begin n_bad++; $display("FAIL done dut%0d cyc%0d: got %b want %b", d, cyc, dn, e_done); end
    n_cmp++;
    if (bsy !== e_busy) begin n_bad++; $display("FAIL busy dut%0d cyc%0d: got %b want %b", d, cyc, bsy, e_busy); end
    n_cmp++;
    if (rdy !== e_rdy) begin n_bad++; $display("FAIL ready dut%0d cyc%0d: got %b want %b", d, cyc, rdy, e_rdy); end
    n_cmp++;
    if ($countones(oen) > 1 || $countones(wen) > 1) begin
      n_bad++; $display("FAIL onehot dut%0d cyc%0d: oen=%h wen=%h, want at most one bit each", d, cyc, oen, wen);
    end
    n_cmp++;
    if (oen != 8'h00 && prev_oen[d] != 8'h00 && oen != prev_oen[d]) begin
      n_bad++; $display("FAIL driver_gap dut%0d cyc%0d: oen %h -> %h, want an idle cycle between", d, cyc, prev_oen[d], oen);
    end
    n_cmp++;
    if (wen != 8'h00 && oen == 8'h00) begin
      n_bad++; $display("FAIL wen_without_oen dut%0d cyc%0d: wen=%h oen=%h, want oen set", d, cyc, wen, oen);
    end
    if (e_rdy != 2'b00 && (e_rdy & vld) != 2'b00) begin
      g = e_rdy[0] ? 0 : 1;
      sbq.push_back('{d, cyc, g,
                      oh((g == 0) ? int'(src[2:0]) : int'(src[5:3]), nreg),
                      oh((g == 0) ? int'(dst[2:0]) : int'(dst[5:3]), nreg)});
      ptr_m[d] = (g + 1) % 2;
      n_acc[d]++;
      last_t[d] = cyc;
      last_g[d] = g;
    end
    n_done[d] += $countones(dn);
    prev_oen[d] = oen;
  endtask

  task automatic step();
    @(negedge clk);
    mon_check(0);
    mon_check(1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic flush(input int d);
    for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].dut == d) sbq.delete(i);
    ptr_m[d] = 0;
  endtask

  task automatic wait_accept(input int d, output int t, output int g);
    int base;
    base = n_acc[d];
    for (int i = 0; i < 20; i++) begin
      step();
      if (n_acc[d] != base) begin t = last_t[d]; g = last_g[d]; return; end
    end
    n_cmp++; n_bad++;
    $display("FAIL accept_timeout dut%0d: no acceptance within 20 cycles, want one", d);
    t = -100; g = -1;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    vld_a = '0; vld_b = '0; src_a = '0; dst_a = '0; src_b = '0; dst_b = '0;
    #2;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    flush(0); flush(1);
    #1;
    n_cmp++;
    if ({oen_a, wen_a, done_a, busy_a} !== 19'd0) begin
      n_bad++; $display("FAIL reset_a: oen=%h wen=%h done=%b busy=%b, want all zero", oen_a, wen_a, done_a, busy_a);
    end
    n_cmp++;
    if ({oen_b, wen_b, done_b, busy_b} !== 15'd0) begin
      n_bad++; $display("FAIL reset_b: oen=%h wen=%h done=%b busy=%b, want all zero", oen_b, wen_b, done_b, busy_b);
    end
    repeat (2) step();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    step();
  endtask

  task automatic test_single();
    int t, g;
    vld_a = 2'b01; src_a = {3'd0, 3'd2}; dst_a = {3'd0, 3'd5};
    wait_accept(0, t, g);
    vld_a = 2'b00;
    n_cmp++;
    if (g !== 0) begin n_bad++; $display("FAIL single_gid: got %0d want 0", g); end
    n_cmp++;
    if (oen_a !== 8'h04 || wen_a !== 8'h00) begin
      n_bad++; $display("FAIL single_drive: oen=%h wen=%h want 04/00", oen_a, wen_a);
    end
    step();
    n_cmp++;
    if (oen_a !== 8'h04 || wen_a !== 8'h20) begin
      n_bad++; $display("FAIL single_write: oen=%h wen=%h want 04/20", oen_a, wen_a);
    end
    step();
    n_cmp++;
    if (done_a !== 2'b01 || oen_a !== 8'h00) begin
      n_bad++; $display("FAIL single_done: done=%b oen=%h want 01/00", done_a, oen_a);
    end
    step();
    n_cmp++;
    if (busy_a !== 1'b0 || done_a !== 2'b00) begin
      n_bad++; $display("FAIL single_idle: busy=%b done=%b want 0/00", busy_a, done_a);
    end
  endtask

  task automatic test_alternate();
    int t, g, prev;
    rst_n_a = 1'b0; flush(0);
    step();
    rst_n_a = 1'b1;
    vld_a = 2'b11; src_a = {3'd3, 3'd1}; dst_a = {3'd4, 3'd2};
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      wait_accept(0, t, g);
      n_cmp++;
      if (g !== i % 2) begin n_bad++; $display("FAIL alt_gid[%0d]: got %0d want %0d", i, g, i % 2); end
      if (i > 0) begin
        n_cmp++;
        if (t - prev !== 4) begin n_bad++; $display("FAIL alt_spacing[%0d]: got %0d want 4", i, t - prev); end
      end
      prev = t;
    end
    vld_a = 2'b00;
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    int t1, g1, t2, g2;
    vld_b = 2'b11; src_b = {3'd4, 3'd1}; dst_b = {3'd1, 3'd3};
    wait_accept(1, t1, g1);
    vld_b = 2'b10;
    n_cmp++;
    if (g1 !== 0 || oen_b !== 6'h02) begin
      n_bad++; $display("FAIL b2b_first: gid=%0d oen=%h want 0/02", g1, oen_b);
    end
    step(); step();
    n_cmp++;
    if (oen_b !== 6'h00) begin n_bad++; $display("FAIL b2b_gap: oen=%h want 00", oen_b); end
    wait_accept(1, t2, g2);
    vld_b = 2'b00;
    n_cmp++;
    if (g2 !== 1 || t2 - t1 !== 3) begin
      n_bad++; $display("FAIL b2b_second: gid=%0d spacing=%0d want 1/3", g2, t2 - t1);
    end
    n_cmp++;
    if (oen_b !== 6'h10) begin n_bad++; $display("FAIL b2b_drive2: oen=%h want 10", oen_b); end
    repeat (4) step();
  endtask

  task automatic test_edge();
    int t, g;
    vld_b = 2'b01; src_b = {3'd0, 3'd3}; dst_b = {3'd0, 3'd3};
    wait_accept(1, t, g);
    vld_b = 2'b00;
    step();
    n_cmp++;
    if (oen_b !== 6'h08 || wen_b !== 6'h08) begin
      n_bad++; $display("FAIL self_reload: oen=%h wen=%h want 08/08", oen_b, wen_b);
    end
    step();
    vld_b = 2'b01; src_b = {3'd0, 3'd7}; dst_b = {3'd0, 3'd6};
    wait_accept(1, t, g);
    vld_b = 2'b00;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (oen_b !== 6'h00 || wen_b !== 6'h00) begin
        n_bad++; $display("FAIL out_of_range[%0d]: oen=%h wen=%h want 00/00", i, oen_b, wen_b);
      end
      step();
    end
    n_cmp++;
    if (done_b !== 2'b01) begin n_bad++; $display("FAIL out_of_range_done: got %b want 01", done_b); end
    repeat (2) step();
  endtask

  task automatic test_mid_reset();
    int t, g, dn0;
    vld_a = 2'b01; src_a = {3'd0, 3'd2}; dst_a = {3'd0, 3'd5};
    wait_accept(0, t, g);
    vld_a = 2'b00;
    step();
    n_cmp++;
    if (oen_a !== 8'h04 || wen_a !== 8'h20) begin
      n_bad++; $display("FAIL midrst_write: oen=%h wen=%h want 04/20", oen_a, wen_a);
    end
    dn0 = n_done[0];
    rst_n_a = 1'b0; flush(0);
    #1;
    n_cmp++;
    if (oen_a !== 8'h00 || wen_a !== 8'h00 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL midrst_clear: oen=%h wen=%h busy=%b want 00/00/0", oen_a, wen_a, busy_a);
    end
    repeat (2) step();
    rst_n_a = 1'b1;
    vld_a = 2'b11; src_a = {3'd6, 3'd0}; dst_a = {3'd7, 3'd1};
    wait_accept(0, t, g);
    vld_a = 2'b00;
    n_cmp++;
    if (g !== 0) begin n_bad++; $display("FAIL midrst_grant: got %0d want 0", g); end
    n_cmp++;
    if (n_done[0] !== dn0) begin n_bad++; $display("FAIL midrst_no_done: done count %0d want %0d", n_done[0], dn0); end
    repeat (5) step();
  endtask

  task automatic test_random();
    int a0[2], d0[2];
    logic [2:0] s, t;
    for (int d = 0; d < 2; d++) begin a0[d] = n_acc[d]; d0[d] = n_done[d]; end
    for (int c = 0; c < 10000; c++) begin
      vld_a = 2'($urandom_range(0, 3));
      src_a = 6'($urandom);
      dst_a = 6'($urandom);
      vld_b = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 7) == 0) begin
          s = 3'(6 + $urandom_range(0, 1)); t = 3'(6 + $urandom_range(0, 1));
        end else begin
          s = 3'($urandom_range(0, 5)); t = 3'($urandom_range(0, 5));
        end
        src_b[r*3 +: 3] = s;
        dst_b[r*3 +: 3] = t;
      end
      step();
    end
    vld_a = 2'b00; vld_b = 2'b00;
    repeat (6) step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (n_done[d] - d0[d] !== n_acc[d] - a0[d]) begin
        n_bad++; $display("FAIL rand_done_count dut%0d: dones %0d want %0d", d, n_done[d] - d0[d], n_acc[d] - a0[d]);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ptr_m[d] = 0; n_acc[d] = 0; n_done[d] = 0; last_t[d] = 0; last_g[d] = 0; prev_oen[d] = '0;
    end
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_edge();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
